// File: rtl/lcd_drv_gen.sv
// HD44780-class character LCD driver: ready/valid word FIFO feeding an RS/E/DB
// waveform generator with tick-based setup, strobe, gap and execution delays.
module lcd_drv_gen #(
  parameter int BUS_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLK_DIV      = 1000,
  parameter int SETUP_TICKS  = 1,
  parameter int STROBE_TICKS = 1,
  parameter int GAP_TICKS    = 1,
  parameter int SHORT_DLY    = 10,
  parameter int LONG_DLY     = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] data_i,
  input  logic       data_valid_i,
  output logic       device_ready_o,
  output logic       busy_o,
  output logic       rs_o,
  output logic       en_o,
  output logic [7:0] lcd_data_o
);
  localparam int M1   = (SETUP_TICKS > STROBE_TICKS) ? SETUP_TICKS : STROBE_TICKS;
  localparam int M2   = (M1 > GAP_TICKS) ? M1 : GAP_TICKS;
  localparam int M3   = (M2 > SHORT_DLY) ? M2 : SHORT_DLY;
  localparam int MAXT = (M3 > LONG_DLY) ? M3 : LONG_DLY;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int PW   = $clog2(CLK_DIV + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam bit FOUR = (BUS_WIDTH == 4);

  typedef enum logic [2:0] {IDLE, SET, STROBE, GAP, DELAY} state_t;
  state_t state, state_n;

  // word FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [9:0]    head;
  logic          push, pop;

  assign device_ready_o = (count != CW'(FIFO_DEPTH)) && !rst_i;
  assign push = data_valid_i && device_ready_o;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = mem[rptr];

  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // per-word context captured at pop
  logic       nib, lng, second;
  logic [3:0] lo;

  // tick timer: restarts on every state entry so each state is N*CLK_DIV cycles
  logic [PW-1:0] pre;
  logic [TW-1:0] tick;
  int            lim;
  logic          tick_end;

  always_comb begin
    lim = 1;
    case (state)
      SET:     lim = SETUP_TICKS;
      STROBE:  lim = STROBE_TICKS;
      GAP:     lim = GAP_TICKS;
      DELAY:   lim = lng ? LONG_DLY : SHORT_DLY;
      default: lim = 1;
    endcase
  end

  assign tick_end = (pre == PW'(CLK_DIV - 1)) && (tick == TW'(lim - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre  <= '0;
      tick <= '0;
    end else if (state_n != state) begin
      pre  <= '0;
      tick <= '0;
    end else if (state != IDLE) begin
      if (pre == PW'(CLK_DIV - 1)) begin
        pre  <= '0;
        tick <= tick + TW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (count != '0) state_n = SET;
      SET:     if (tick_end) state_n = STROBE;
      STROBE:  if (tick_end) state_n = (FOUR && !second && !nib) ? GAP : DELAY;
      GAP:     if (tick_end) state_n = SET;
      DELAY:   if (tick_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs_o       <= 1'b0;
      en_o       <= 1'b0;
      lcd_data_o <= '0;
      busy_o     <= 1'b0;
      nib        <= 1'b0;
      lng        <= 1'b0;
      second     <= 1'b0;
      lo         <= '0;
    end else begin
      busy_o <= (state != IDLE) || (count != '0);
      en_o   <= (state_n == STROBE);
      if (pop) begin
        rs_o       <= head[8];
        lcd_data_o <= FOUR ? {head[7:4], 4'b0} : head[7:0];
        nib        <= head[9];
        lng        <= !head[8] && (head[7:2] == 6'd0);
        second     <= 1'b0;
        lo         <= head[3:0];
      end
      if (state == STROBE && state_n == GAP) begin
        lcd_data_o <= {lo, 4'b0};
        second     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_drv_gen.sv
// Directed bench for lcd_drv_gen: an 8-bit and a 4-bit instance with
// CLK_DIV=4, SETUP=1, STROBE=2, GAP=1, SHORT=10, LONG=50.
module tb_lcd_drv_gen;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] d8, d4;
  logic v8, v4;
  logic rdy8, busy8, rs8, en8, rdy4, busy4, rs4, en4;
  logic [7:0] lcd8, lcd4;

  always #5 clk = ~clk;

  lcd_drv_gen #(.BUS_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(4), .SETUP_TICKS(1),
    .STROBE_TICKS(2), .GAP_TICKS(1), .SHORT_DLY(10), .LONG_DLY(50)) dut8 (
    .clk_i(clk), .rst_i(rst), .data_i(d8), .data_valid_i(v8),
    .device_ready_o(rdy8), .busy_o(busy8), .rs_o(rs8), .en_o(en8), .lcd_data_o(lcd8));

  lcd_drv_gen #(.BUS_WIDTH(4), .FIFO_DEPTH(4), .CLK_DIV(4), .SETUP_TICKS(1),
    .STROBE_TICKS(2), .GAP_TICKS(1), .SHORT_DLY(10), .LONG_DLY(50)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(d4), .data_valid_i(v4),
    .device_ready_o(rdy4), .busy_o(busy4), .rs_o(rs4), .en_o(en4), .lcd_data_o(lcd4));

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // en rise logger for the 8-bit instance
  logic       log_on = 1'b0;
  logic       en8_prev = 1'b0;
  logic [7:0] log_q [16];
  int         nlog = 0;
  always @(negedge clk) begin
    if (log_on) begin
      if (en8 && !en8_prev && nlog < 16) begin
        log_q[nlog] = lcd8;
        nlog = nlog + 1;
      end
      en8_prev = en8;
    end
  end

  typedef struct {
    bit         four;
    logic [9:0] word;
    int         rs;
    int         d1;     // lcd_data at first strobe
    int         d2;     // lcd_data at last strobe
    int         rise2;  // k of last en rise (k = samples after edge E1+k)
    int         hi;     // total en-high cycles
    int         npulse;
    int         fall;   // k where busy first reads low = total+1
  } vec_t;

  vec_t vt[8];

  task automatic wait_idle();
    int t = 0;
    while ((busy8 || busy4) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, rises, hi, r1, r2, lastlcd;
    logic prev, en_s, busy_s, rs_s;
    logic [7:0] lcd_s;
    wait_idle();
    @(negedge clk);
    if (v.four) begin d4 = v.word; v4 = 1'b1; end
    else        begin d8 = v.word; v8 = 1'b1; end
    @(posedge clk);  // E0: word accepted
    @(negedge clk);
    v4 = 1'b0; v8 = 1'b0;
    @(posedge clk);  // E1: popped, SET entered
    k = 0; rises = 0; hi = 0; r1 = -1; r2 = -1; lastlcd = -1; prev = 1'b0;
    while (k < 700) begin
      @(negedge clk);
      en_s   = v.four ? en4 : en8;
      busy_s = v.four ? busy4 : busy8;
      rs_s   = v.four ? rs4 : rs8;
      lcd_s  = v.four ? lcd4 : lcd8;
      if (k == 0) begin
        chk($sformatf("v%0d_rs", idx), int'(rs_s), v.rs);
        chk($sformatf("v%0d_lcd_first", idx), int'(lcd_s), v.d1);
      end
      if (en_s && !prev) begin
        rises++;
        if (rises == 1) r1 = k;
        r2 = k;
        lastlcd = int'(lcd_s);
      end
      if (en_s) hi++;
      prev = en_s;
      if (!busy_s) break;
      k++;
    end
    chk($sformatf("v%0d_en_rise", idx), r1, 4);
    chk($sformatf("v%0d_en_rise_last", idx), r2, v.rise2);
    chk($sformatf("v%0d_en_high", idx), hi, v.hi);
    chk($sformatf("v%0d_pulses", idx), rises, v.npulse);
    chk($sformatf("v%0d_lcd_last", idx), lastlcd, v.d2);
    chk($sformatf("v%0d_total", idx), k, v.fall);
  endtask

  initial begin
    logic [9:0] w [6];
    int e, i, acc6, lowseen, last, cnt;
    logic acc;

    //          four word    rs  d1    d2    rise2 hi  np fall
    vt[0] = '{1'b0, 10'h141, 1, 'h41, 'h41, 4,  8,  1, 53};
    vt[1] = '{1'b0, 10'h001, 0, 'h01, 'h01, 4,  8,  1, 213};
    vt[2] = '{1'b0, 10'h002, 0, 'h02, 'h02, 4,  8,  1, 213};
    vt[3] = '{1'b0, 10'h006, 0, 'h06, 'h06, 4,  8,  1, 53};
    vt[4] = '{1'b1, 10'h128, 1, 'h20, 'h80, 20, 16, 2, 69};
    vt[5] = '{1'b1, 10'h203, 0, 'h00, 'h00, 4,  8,  1, 213};
    vt[6] = '{1'b0, 10'h203, 0, 'h03, 'h03, 4,  8,  1, 213};
    vt[7] = '{1'b1, 10'h1A5, 1, 'hA0, 'h50, 20, 16, 2, 69};

    rst = 1'b1; v8 = 1'b0; v4 = 1'b0; d8 = '0; d4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rs", int'(rs8), 0);
    chk("rst_en", int'(en8), 0);
    chk("rst_lcd", int'(lcd8), 0);
    chk("rst_busy", int'(busy8 | busy4), 0);
    chk("rst_ready_in_reset", int'(rdy8), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", int'(rdy8 & rdy4), 1);

    for (int n = 0; n < 8; n++) run_vec(vt[n], n);

    // reset in the middle of a strobe
    wait_idle();
    @(negedge clk); d8 = 10'h141; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk); v8 = 1'b0;
    cnt = 0;
    while (!en8 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("mid_strobe_reached", int'(en8), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_en", int'(en8), 0);
    chk("mid_rst_lcd", int'(lcd8), 0);
    chk("mid_rst_rs", int'(rs8), 0);
    chk("mid_rst_busy", int'(busy8), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready", int'(rdy8), 1);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy8 || en8) cnt++;
    end
    chk("mid_rst_discarded", cnt, 0);

    // FIFO back-pressure: six words into a depth-4 FIFO
    for (int n = 0; n < 6; n++) w[n] = 10'h141 + 10'(n);
    nlog = 0; en8_prev = 1'b0; log_on = 1'b1;
    e = 0; i = 0; acc6 = -1; lowseen = 0;
    while (i < 6 && e < 200) begin
      @(negedge clk);
      d8 = w[i]; v8 = 1'b1;
      acc = rdy8;
      if (!rdy8) lowseen++;
      @(posedge clk);
      if (acc) begin
        if (i == 5) acc6 = e;
        i++;
      end
      e++;
    end
    chk("fifo_6th_accept_edge", acc6, 55);
    chk("fifo_ready_low_cycles", lowseen, 50);
    last = e - 1;
    while (last < 2000) begin
      @(negedge clk);
      v8 = 1'b0;
      if (!busy8) break;
      @(posedge clk);
      last++;
    end
    chk("fifo_busy_fall_edge", last, 319);
    log_on = 1'b0;
    chk("fifo_word_count", nlog, 6);
    for (int n = 0; n < 6; n++)
      chk($sformatf("fifo_order_%0d", n), int'(log_q[n]), 'h41 + n);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/lcd_drv_gen.md
# lcd_drv_gen

Parametrised HD44780-class character-LCD driver: accepts register-select/data words over a ready/valid bus, buffers them in a small FIFO, and generates the RS/E/DB waveforms with programmable setup, strobe, and execution delays. Adds a 4-bit bus mode with two-nibble transfers and a single-nibble flag for the 4-bit init sequence. Sits between the system-side command source (text/init sequencer) and the LCD pins.

## Interface
- BUS_WIDTH, 8, LCD data bus width: 8 or 4
- FIFO_DEPTH, 4, input word buffer depth; power of 2, ≥2
- CLK_DIV, 1000, clock cycles per timing tick
- SETUP_TICKS, 1, ticks RS/DB are stable before E rises
- STROBE_TICKS, 1, ticks E is high
- GAP_TICKS, 1, ticks E is low between the two nibbles (4-bit mode)
- SHORT_DLY, 10, execution delay ticks for ordinary words
- LONG_DLY, 250, execution delay ticks for clear/home (rs=0, data[7:2]==0)
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- data_i  in  10  {nib_only, rs, data[7:0]}
- data_valid_i  in  1  data_i valid
- device_ready_o  out  1  FIFO can accept a word
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- rs_o  out  1  register select
- en_o  out  1  enable strobe
- lcd_data_o  out  8  LCD data; in 4-bit mode nibble on [7:4], [3:0]=0

## Operation
- Reset values: rs_o=0, en_o=0, lcd_data_o=0, busy_o=0, FIFO empty, FSM IDLE. device_ready_o = (count != FIFO_DEPTH) && !rst_i.
- Push: data_valid_i && device_ready_o at a rising edge writes data_i; words offered while full are not taken and the source holds them.
- FSM states: IDLE, SET, STROBE, GAP, DELAY. All outputs registered.
- IDLE: FIFO non-empty → pop, load rs_o; 8-bit mode: lcd_data_o=data; 4-bit mode: lcd_data_o={data[7:4],4'b0}; go SET. Record nib_only and long-delay flag.
- SET → STROBE after SETUP_TICKS; en_o=1 throughout STROBE.
- STROBE → GAP after STROBE_TICKS if 4-bit mode, first nibble, nib_only=0; on GAP entry lcd_data_o={data[3:0],4'b0}. Otherwise → DELAY.
- GAP (en_o=0) → SET after GAP_TICKS (second nibble).
- DELAY → IDLE after LONG_DLY ticks if rs=0 && data[7:2]==0, else SHORT_DLY.
- In 8-bit mode nib_only is ignored; GAP is never entered.
- Tick counter: prescaler 0..CLK_DIV-1 and tick count both clear on every state entry, so each state lasts exactly N*CLK_DIV cycles. Widths are $clog2 of the largest parameter value, no wrap inside a state.
- Push and pop in the same cycle are allowed; the count stays the same.
- Reset mid-transfer: en_o drops asynchronously, FIFO is flushed, all outputs go to reset values, and the partial transfer is discarded.

## Timing
- Push at edge E0 → pop and SET entry at E1 (rs_o/lcd_data_o valid after E1) when the FSM is idle.
- en_o rises at E1 + SETUP_TICKS*CLK_DIV and stays high for STROBE_TICKS*CLK_DIV cycles.
- 8-bit word total (E1 to IDLE re-entry): (SETUP+STROBE+dly)*CLK_DIV cycles.
- 4-bit full word: (2*SETUP+2*STROBE+GAP+dly)*CLK_DIV cycles.
- The next word pops on the cycle after IDLE entry (one IDLE cycle between words).
- busy_o falls in the cycle after IDLE entry with an empty FIFO.

## Test plan
Common settings: CLK_DIV=4, SETUP=1, STROBE=2, GAP=1, SHORT=10, LONG=50.
- Reset: assert rst_i mid-STROBE → en_o=0 immediately, lcd_data_o=0, device_ready_o=1 one cycle after release, busy_o=0.
- 8-bit mode, push 0x141 (rs=1, 'A') → rs_o=1, lcd_data_o=0x41; en_o high cycles 5–12 after E1; IDLE after 52 cycles.
- 8-bit mode, push 0x001 (clear) → DELAY lasts 200 cycles; push 0x002 also uses 200; push 0x006 uses 40.
- 4-bit mode, push 0x128 → lcd_data_o 0x20 then 0x80; two 8-cycle en_o pulses separated by 4+4 low cycles.
- 4-bit mode, push 0x203 (nib_only) → one strobe with lcd_data_o=0x00 then DELAY.
- FIFO_DEPTH=4: push 6 words back-to-back → device_ready_o low after the 4th until the first pop; all 6 emitted in order; busy_o stays high until the last DELAY ends.
